// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that adds one 4-bit nibble per clock,
// starting at the LSB. A single 4-bit ripple-carry adder is reused on every
// step. A registered carry links each nibble to the next one.
// Handshakes use valid/ready on both sides. out_valid, in_ready and busy come
// straight from registers, so no input reaches an output combinationally.

// 4-bit ripple-carry adder: the one adder stage that the sequencer reuses
module nibble_serial_adder_rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry_s;

    // Ripple the carry through four full-adder bit slices
    always_comb begin
        carry_s    = 5'b00000;
        sum        = 4'b0000;
        carry_s[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
        cout = carry_s[4];
    end

endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IDXW-1:0]  idx_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [3:0]       rca_a_s;
    logic [3:0]       rca_b_s;
    logic [3:0]       rca_sum_s;
    logic             rca_cout_s;

    // Select the nibble that the current step works on from the latched operands
    always_comb begin
        rca_a_s = a_r[{idx_r, 2'b00} +: 4];
        rca_b_s = b_r[{idx_r, 2'b00} +: 4];
    end

    nibble_serial_adder_rca u_rca (
        .a    (rca_a_s),
        .b    (rca_b_s),
        .cin  (carry_r),
        .sum  (rca_sum_s),
        .cout (rca_cout_s)
    );

    // Sequencer: accept operands, step through the nibbles, hold the result until it is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            idx_r       <= IDX_ZERO;
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= b;
                        carry_r    <= cin;
                        idx_r      <= IDX_ZERO;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= CALC;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                CALC: begin
                    sum_r[{idx_r, 2'b00} +: 4] <= rca_sum_s;
                    carry_r                    <= rca_cout_s;
                    idx_r                      <= idx_r + IDX_ONE;
                    if (idx_r == LAST_IDX) begin
                        cout_r      <= rca_cout_s;
                        // The top nibble's sum bit 3 is the new result MSB
                        ovf_r       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &
                                       (rca_sum_s[3] != a_r[WIDTH-1]);
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r     <= CALC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=8). It checks directed
// corner cases and randomized adds against a plain arithmetic reference.
module tb_nibble_serial_adder;

    localparam int W       = 8;
    localparam int NIB     = W / 4;
    localparam int TIMEOUT = 20;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_cmp;
    int n_mis;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete add. The reference is {cout,sum} = a+b+cin; ovf is derived from the operand and result signs.
    // 'stall' is the number of DONE cycles with out_ready low; 'noise' drives junk operands while busy.
    task automatic do_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input int stall, input bit noise);
        logic [W:0]   full;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           edges;
        full = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
        es   = full[W-1:0];
        ec   = full[W];
        eo   = (xa[W-1] == xb[W-1]) && (es[W-1] != xa[W-1]);

        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; a = xa; b = xb; cin = xc;
        tick();
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        edges = 0;
        while (!out_valid && edges < TIMEOUT) begin
            if (noise) begin
                in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            tick();
            edges++;
        end
        chk("latency", edges, NIB);
        chk("busy_done", {31'd0, busy}, 32'd1);
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        chk("sum", {24'd0, sum}, {24'd0, es});
        chk("cout", {31'd0, cout}, {31'd0, ec});
        chk("ovf", {31'd0, ovf}, {31'd0, eo});
        for (int s = 0; s < stall; s++) begin
            if (noise) begin
                in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            tick();
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_sum", {24'd0, sum}, {24'd0, es});
            chk("stall_cout", {31'd0, cout}, {31'd0, ec});
            chk("stall_ovf", {31'd0, ovf}, {31'd0, eo});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ret_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ret_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ret_busy", {31'd0, busy}, 32'd0);
        chk("ret_sum_hold", {24'd0, sum}, {24'd0, es});
    endtask

    // Test sequence
    initial begin
        n_cmp = 0; n_mis = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        tick();

        do_add(8'h3C, 8'h15, 1'b0, 0, 1'b0);
        do_add(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        do_add(8'h0F, 8'h00, 1'b1, 0, 1'b0);
        do_add(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        do_add(8'h80, 8'h80, 1'b0, 0, 1'b0);
        do_add(8'hFF, 8'hFF, 1'b1, 5, 1'b0);
        do_add(8'h12, 8'h34, 1'b1, 5, 1'b1);

        // Reset after the first nibble step
        in_valid = 1'b1; a = 8'hC3; b = 8'h5A; cin = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_sum", {24'd0, sum}, 32'd0);
        chk("mid_rst_cout", {31'd0, cout}, 32'd0);
        chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        do_add(8'hAA, 8'h55, 1'b0, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            do_add(W'($urandom), W'($urandom), 1'($urandom),
                   (($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0),
                   1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Absolute time limit so the run cannot hang
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, got running, expected finished");
        $fatal(1);
    end

endmodule
